omsp_spm_key_writer: RTL and testbench
======================================

Name: omsp_spm_key_writer

Overview:
Sequencer that loads a freshly derived SM key into the SPM array, one 16-bit word per write. It sits directly upstream of the SPM control block and drives that block's write_key / key_in / key_idx inputs. Key words arrive from the key-derivation source over a valid/ready stream; the block is started by the Sancus instruction FSM once a new SM has been enabled. It reports done, or error on abort or stall timeout.

Parameters:
KEY_WORDS, 4, number of 16-bit words per key (`SECURITY/16; 64-bit key gives 4).
KEY_IDX_SIZE, 2, width of key_idx; must satisfy 2**KEY_IDX_SIZE >= KEY_WORDS.
TIMEOUT, 255, maximum consecutive FILL cycles without an accepted word before error; range 1..65535.

Ports:
mclk  in  1  system clock
puc_rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin loading a key
abort  in  1  cancel an in-progress load
kw_data  in  16  key word from derivation source; word 0 = key bits [0:15] (MSB-first)
kw_valid  in  1  kw_data valid
kw_ready  out  1  block accepts a word this cycle
write_key  out  1  key word write strobe to SPM control
key_in  out  16  key word to write
key_idx  out  KEY_IDX_SIZE  word index within key
busy  out  1  load in progress
done  out  1  single-cycle pulse: final word written
error  out  1  single-cycle pulse: load cancelled (abort or timeout)

Behaviour:
- Reset (puc_rst_n low, async): state IDLE. write_key, key_in, key_idx, busy, done, error, word counter and timer all 0. kw_ready = 0.
- States: IDLE, FILL. kw_ready = (state == FILL) && !abort. This is the only combinational output. busy = (state == FILL).
- IDLE: start && !abort moves to FILL with counter = 0 and timer = 0. abort in IDLE is ignored and produces no error. start && abort keeps the block in IDLE with no error.
- FILL, accept = kw_valid && kw_ready:
  - Next cycle: write_key = 1, key_in = kw_data, key_idx = counter (registered; 1-cycle latency).
  - Counter increments and timer clears.
  - If counter == KEY_WORDS-1 at accept: go to IDLE, and done = 1 in the same cycle as that final write_key.
- write_key is 0 in every cycle not immediately following an accept. key_in and key_idx hold their last values when write_key = 0.
- FILL with no accept: timer increments. When timer == TIMEOUT-1 with no accept that cycle, go to IDLE and pulse error next cycle. The counter is discarded and no write occurs.
- abort in FILL: go to IDLE and pulse error next cycle. A kw_valid in the same cycle is not accepted (kw_ready = 0), so no write occurs. Words already written are not rolled back; the SPM holds a partial key and the FSM must treat error as fatal for that SM.
- start while in FILL is ignored; the current load continues.
- Back-to-back start the cycle after done is legal and begins a new load.
- Counter width is KEY_IDX_SIZE+1 with no wrap; the terminal compare is exact.
- Timer width is 16 bits and saturates implicitly because FILL exits at TIMEOUT-1.
- done and error are never high in the same cycle. abort dominates a simultaneous final accept: error = 1, done = 0, no final write.

Decomposition:
- openMSP430_defines.v: `SECURITY already present; add `SPM_KEY_WORDS = `SECURITY/16.
- State encoding as local parameters inside the module (2 states, 1 bit).
- No sub-module. The timeout counter is inlined; the block is small enough to remain a single module.

Test Plan:
- Nominal: start, then kw_valid held high with words 16'h1111, 16'h2222, 16'h3333, 16'h4444 -> write_key high 4 consecutive cycles with key_idx 0,1,2,3 and the matching key_in; done = 1 alongside idx 3; busy falls the same cycle; error never set.
- Gapped source: valid low 3 cycles between each of 4 words, TIMEOUT = 255 -> 4 writes, done, no error; timer clears on each accept.
- Timeout: TIMEOUT = 8, start, one word accepted, then valid low -> error pulse exactly 8 cycles after that accept; only one write_key (idx 0); no done; state IDLE.
- Abort vs final accept: abort asserted in the same cycle as the 4th kw_valid -> kw_ready = 0, only 3 writes, error = 1, done = 0.
- Ignored requests: start pulsed during FILL after word 1, and abort pulsed in IDLE -> load completes normally with idx 0..3; no error from the idle abort.
- Reset mid-load: drop puc_rst_n after word 2 -> all outputs 0 immediately (async); after release the block stays IDLE until a new start.

Source files
------------

// File: rtl/omsp_spm_key_writer_pkg.sv
// Shared types and widths for the SPM key-word write sequencer.
package omsp_spm_key_writer_pkg;

  localparam int unsigned KwDataW  = 16;
  localparam int unsigned KwTimerW = 16;

  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } kw_state_e;

endpackage

// File: rtl/omsp_spm_key_writer.sv
// Streams a freshly derived SM key into the SPM control block one 16-bit word at a time,
// reporting done after the last word, or error on abort / source stall timeout.
module omsp_spm_key_writer
  import omsp_spm_key_writer_pkg::*;
#(
  parameter int unsigned KEY_WORDS    = 4,
  parameter int unsigned KEY_IDX_SIZE = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                    mclk,
  input  logic                    puc_rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [KwDataW-1:0]      kw_data,
  input  logic                    kw_valid,
  output logic                    kw_ready,
  output logic                    write_key,
  output logic [KwDataW-1:0]      key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned CntW = KEY_IDX_SIZE + 1;
  localparam logic [CntW-1:0]     LastWord    = CntW'(KEY_WORDS - 1);
  localparam logic [KwTimerW-1:0] TimeoutLast = KwTimerW'(TIMEOUT - 1);

  kw_state_e             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [KwTimerW-1:0]   timer_q, timer_d;
  logic                  write_key_q, write_key_d;
  logic [KwDataW-1:0]    key_in_q, key_in_d;
  logic [KEY_IDX_SIZE-1:0] key_idx_q, key_idx_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  accept;

  // State register
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    write_key_d = 1'b0;
    key_in_d    = key_in_q;
    key_idx_d   = key_idx_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    case (state_q)
      StIdle: begin
        // abort in IDLE is silently ignored, and also vetoes a simultaneous start
        if (start && !abort) begin
          state_d = StFill;
          cnt_d   = '0;
          timer_d = '0;
        end
      end
      StFill: begin
        if (abort) begin
          state_d = StIdle;
          error_d = 1'b1;
          cnt_d   = '0;
          timer_d = '0;
        end else if (accept) begin
          write_key_d = 1'b1;
          key_in_d    = kw_data;
          key_idx_d   = cnt_q[KEY_IDX_SIZE-1:0];
          timer_d     = '0;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LastWord) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else if (timer_q == TimeoutLast) begin
          // Partial key already written stays in the SPM; the FSM treats error as fatal
          state_d = StIdle;
          error_d = 1'b1;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Combinational outputs
  always_comb begin
    kw_ready = (state_q == StFill) && !abort;
    busy     = (state_q == StFill);
    accept   = kw_valid && kw_ready;
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      cnt_q       <= '0;
      timer_q     <= '0;
      write_key_q <= 1'b0;
      key_in_q    <= '0;
      key_idx_q   <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      write_key_q <= write_key_d;
      key_in_q    <= key_in_d;
      key_idx_q   <= key_idx_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign write_key = write_key_q;
  assign key_in    = key_in_q;
  assign key_idx   = key_idx_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_omsp_spm_key_writer.sv
// Scoreboard bench for omsp_spm_key_writer: accepted words are queued and matched
// against the write_key stream; done/error pulses are counted and timed.
module tb_omsp_spm_key_writer;

  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] kw_data = '0;
  logic        kw_valid = 1'b0;
  logic        kw_ready;
  logic        write_key;
  logic [15:0] key_in;
  logic [1:0]  key_idx;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_done = 0;
  int n_err = 0;
  int last_wr_cyc = 0;
  int last_err_cyc = 0;
  int next_idx = 0;
  exp_t sb[$];
  exp_t e;

  omsp_spm_key_writer #(
    .KEY_WORDS   (4),
    .KEY_IDX_SIZE(2),
    .TIMEOUT     (TO)
  ) u_dut (
    .mclk     (mclk),
    .puc_rst_n(puc_rst_n),
    .start    (start),
    .abort    (abort),
    .kw_data  (kw_data),
    .kw_valid (kw_valid),
    .kw_ready (kw_ready),
    .write_key(write_key),
    .key_in   (key_in),
    .key_idx  (key_idx),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every write and time the done/error pulses
  always @(negedge mclk) begin
    if (write_key) begin
      n_wr++;
      last_wr_cyc = cyc;
      check_val("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("key_idx", 32'(key_idx), 32'(e.idx));
        check_val("key_in", 32'(key_in), 32'(e.data));
        check_val("done_with_wr", 32'(done), 32'(e.last));
      end
    end
    if (done) begin
      n_done++;
      check_val("done_has_wr", 32'(write_key), 32'd1);
      check_val("busy_at_done", 32'(busy), 32'd0);
    end
    if (error) begin
      n_err++;
      last_err_cyc = cyc;
      check_val("err_no_done", 32'(done), 32'd0);
      check_val("err_no_wr", 32'(write_key), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    next_idx = 0;
  endtask

  // Present a word after 'gap' idle cycles and wait (bounded) for it to be accepted
  task automatic send_word(input logic [15:0] d, input int gap, input logic last);
    bit got = 0;
    if (gap > 0) begin
      kw_valid = 1'b0;
      tick(gap);
    end
    kw_valid = 1'b1;
    kw_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge mclk);
      if (kw_ready) begin
        sb.push_back('{idx: 2'(next_idx), data: d, last: last});
        next_idx++;
        got = 1;
        tick(1);
        break;
      end
    end
    if (!got) check_val("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_key(input logic [15:0] base, input int gap);
    pulse_start();
    for (int w = 0; w < 4; w++) send_word(base * 16'(w + 1), gap, w == 3);
    kw_valid = 1'b0;
  endtask

  int wr0, dn0, er0;

  initial begin
    #1 puc_rst_n = 1'b0;
    #2;
    check_val("rst_write_key", 32'(write_key), 32'd0);
    check_val("rst_key_in", 32'(key_in), 32'd0);
    check_val("rst_key_idx", 32'(key_idx), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_error", 32'(error), 32'd0);
    check_val("rst_kw_ready", 32'(kw_ready), 32'd0);
    tick(2);
    puc_rst_n = 1'b1;
    tick(2);

    // Nominal, valid held high: four back-to-back writes
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    check_val("idle_ready", 32'(kw_ready), 32'd0);
    load_key(16'h1111, 0);
    tick(2);
    check_val("nom_writes", 32'(n_wr - wr0), 32'd4);
    check_val("nom_done", 32'(n_done - dn0), 32'd1);
    check_val("nom_error", 32'(n_err - er0), 32'd0);

    // Gapped source: total stall exceeds TIMEOUT, so the timer must clear per accept
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    load_key(16'h0A05, 3);
    tick(2);
    check_val("gap_writes", 32'(n_wr - wr0), 32'd4);
    check_val("gap_done", 32'(n_done - dn0), 32'd1);
    check_val("gap_error", 32'(n_err - er0), 32'd0);

    // Timeout after one word
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    pulse_start();
    send_word(16'hBEEF, 0, 1'b0);
    kw_valid = 1'b0;
    for (int i = 0; i < 30 && n_err == er0; i++) tick(1);
    check_val("to_error", 32'(n_err - er0), 32'd1);
    check_val("to_latency", 32'(last_err_cyc - last_wr_cyc), 32'(TO));
    check_val("to_writes", 32'(n_wr - wr0), 32'd1);
    check_val("to_done", 32'(n_done - dn0), 32'd0);
    check_val("to_busy", 32'(busy), 32'd0);

    // Abort coincident with the final word
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    pulse_start();
    for (int w = 0; w < 3; w++) send_word(16'h5000 + 16'(w), 0, 1'b0);
    kw_data  = 16'h4444;
    kw_valid = 1'b1;
    abort    = 1'b1;
    @(negedge mclk);
    check_val("abort_ready", 32'(kw_ready), 32'd0);
    tick(1);
    abort    = 1'b0;
    kw_valid = 1'b0;
    tick(2);
    check_val("abort_writes", 32'(n_wr - wr0), 32'd3);
    check_val("abort_error", 32'(n_err - er0), 32'd1);
    check_val("abort_done", 32'(n_done - dn0), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);

    // Start during FILL and abort in IDLE are both ignored
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    pulse_start();
    send_word(16'hC001, 0, 1'b0);
    kw_valid = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int w = 1; w < 4; w++) send_word(16'hC001 + 16'(w), 1, w == 3);
    kw_valid = 1'b0;
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(2);
    check_val("ign_writes", 32'(n_wr - wr0), 32'd4);
    check_val("ign_done", 32'(n_done - dn0), 32'd1);
    check_val("ign_error", 32'(n_err - er0), 32'd0);

    // Back-to-back loads: second start issued right behind done
    wr0 = n_wr; dn0 = n_done;
    load_key(16'h0101, 0);
    load_key(16'h0202, 0);
    tick(2);
    check_val("b2b_writes", 32'(n_wr - wr0), 32'd8);
    check_val("b2b_done", 32'(n_done - dn0), 32'd2);

    // Asynchronous reset mid-load
    wr0 = n_wr;
    pulse_start();
    send_word(16'h1234, 0, 1'b0);
    send_word(16'h5678, 0, 1'b0);
    @(negedge mclk);
    #1 puc_rst_n = 1'b0;
    #1;
    check_val("mrst_write_key", 32'(write_key), 32'd0);
    check_val("mrst_key_in", 32'(key_in), 32'd0);
    check_val("mrst_key_idx", 32'(key_idx), 32'd0);
    check_val("mrst_busy", 32'(busy), 32'd0);
    check_val("mrst_kw_ready", 32'(kw_ready), 32'd0);
    tick(1);
    puc_rst_n = 1'b1;
    tick(5);
    check_val("mrst_writes", 32'(n_wr - wr0), 32'd2);
    check_val("mrst_idle_busy", 32'(busy), 32'd0);
    check_val("mrst_idle_ready", 32'(kw_ready), 32'd0);
    kw_valid = 1'b0;
    check_val("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule
